// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient pattern reported on divide-by-zero, sliced to WIDTH at use.
    localparam logic [63:0] ALL_ONES = '1;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/ripple_subtractor.sv
// rtl/ripple_subtractor.sv - N-bit a - b as a + ~b + 1 over a full_adder chain
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i    (a_i[i]),
            .b_i    (~b_i[i]),
            .cin_i  (carry[i]),
            .sum_o  (diff_o[i]),
            .cout_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement truncating division.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] rem_d, quo_d, q_fix, r_fix, dvd_mag, dvs_mag;
    logic [WIDTH:0]   trial_a, trial_diff;
    logic             trial_borrow, sub_msb_unused;

    // Shifted partial remainder picks up the next dividend bit from the quotient register.
    assign trial_a = {rem_q, quo_q[WIDTH-1]};

    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .a_i      (trial_a),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    assign sub_msb_unused = trial_diff[WIDTH];
    assign rem_d = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, rneg_q;

    // Magnitude of the most-negative value wraps to itself, which is the right unsigned magnitude.
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix   = qneg_q ? -quo_d : quo_d;
    assign r_fix   = rneg_q ? -rem_d : rem_d;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fix   = quo_d;
    assign r_fix   = rem_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        dvs_q  <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_q <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            quotient_q  <= ALL_ONES[WIDTH-1:0];
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dvd_mag;
                            count_q <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        quotient_q  <= q_fix;
                        remainder_q <= r_fix;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int lat, bcnt;

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input int a, input int b);
        start    = 1'b1;
        dividend = 4'(a);
        divisor  = 4'(b);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_done(input int n0, output int n, output int bc);
        n  = n0;
        bc = n0 - 1;
        forever begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1 || n >= 40) break;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int elat, input int eq,
                                input int er, input int ez);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_busy_cycles"}, bcnt, elat);
        chk({tag, "_done_busy"}, int'(busy), 1);
        chk({tag, "_q"}, int'(quotient), eq);
        chk({tag, "_r"}, int'(remainder), er);
        chk({tag, "_dbz"}, int'(div_by_zero), ez);
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_held_q"}, int'(quotient), eq);
        chk({tag, "_held_r"}, int'(remainder), er);
        chk({tag, "_held_dbz"}, int'(div_by_zero), ez);
    endtask

    task automatic run(input string tag, input int a, input int b, input int elat,
                       input int eq, input int er, input int ez);
        issue(a, b);
        wait_done(1, lat, bcnt);
        check_result(tag, elat, eq, er, ez);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run("u13_3", 13, 3, 5, 4, 1, 0);
        run("dbz7_0", 7, 0, 1, 15, 7, 1);

        issue(9, 2);
        chk("dbz_clear_on_accept", int'(div_by_zero), 0);
        wait_done(1, lat, bcnt);
        check_result("u9_2", 5, 4, 1, 0);

        run("u15_1", 15, 1, 5, 15, 0, 0);
        run("u2_15", 2, 15, 5, 0, 2, 0);
        run("u15_15", 15, 15, 5, 1, 0, 0);

        // Second start lands in the first CALC cycle and must be ignored.
        issue(14, 4);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_done(2, lat, bcnt);
        check_result("ignore14_4", 5, 3, 2, 0);

        run("b2b6_2", 6, 2, 5, 3, 0, 0);

        issue(11, 2);
        @(posedge clk); #1;
        chk("mid_busy_pre", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_q", int'(quotient), 0);
        chk("async_r", int'(remainder), 0);
        chk("async_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run("after_rst11_2", 11, 2, 5, 5, 1, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run("s_m7_2", 4'b1001, 2, 5, 4'b1101, 4'b1111, 0);
        run("s_m8_m1", 4'b1000, 4'b1111, 5, 4'b1000, 0, 0);
        run("s_7_m2", 7, 4'b1110, 5, 4'b1101, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
